mem_arbiter: RTL and testbench

Two-port arbiter that shares a single synchronous MemoryUnit between the CPU's instruction-fetch port and its data port, allowing a unified program/data memory in `computer`. It sits between `Cpu` and one `MemoryUnit` and sequences each access as a registered issue/capture transaction. Each requester uses a req/ack handshake. Data accesses have priority over fetches, with an optional starvation guard for fetches.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one synchronous MemoryUnit between the CPU fetch and data ports, one transaction per 3 cycles.
// Define MEM_ARB_STARVE_GUARD_EN to add the fetch starvation guard (streak counter, forced fetch).
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_rdata_i
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_e;

  state_e      state_q, state_d;
  logic        own_d_q, own_d_d;   // 1: data port owns the transaction
  logic        wr_q, wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_write_q, mem_write_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        grant_d, grant_if, force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] streak_q, streak_d;

  assign force_if = if_req_i && (streak_q == LIMIT);

  always_comb begin
    streak_d = streak_q;
    if (grant_if)
      streak_d = '0;
    else if (grant_d)
      streak_d = !if_req_i ? 4'd0 : (streak_q == LIMIT) ? streak_q : streak_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) streak_q <= '0;
    else          streak_q <= streak_d;
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    own_d_d     = own_d_q;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = mem_write_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    grant_d     = 1'b0;
    grant_if    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_req_i && !force_if) grant_d = 1'b1;
        else if (if_req_i)        grant_if = 1'b1;
        if (grant_d) begin
          mem_addr_d = d_addr_i;
          own_d_d    = 1'b1;
          wr_d       = d_we_i;
          if (d_we_i) begin
            mem_wdata_d = d_wdata_i;
            mem_write_d = 1'b1;
          end
          state_d = S_ISSUE;
        end else if (grant_if) begin
          mem_addr_d = if_addr_i;
          own_d_d    = 1'b0;
          wr_d       = 1'b0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_write_d = 1'b0;
        state_d     = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Writes complete with an ack but leave d_rdata untouched.
        if (own_d_q) begin
          d_ack_d = 1'b1;
          if (!wr_q) d_rdata_d = mem_rdata_i;
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata_i;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      own_d_q     <= 1'b0;
      wr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      own_d_q     <= own_d_d;
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_write_o = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory behind it.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, d_ack, mem_write;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack), .d_rdata_o(d_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_write_o(mem_write),
    .mem_rdata_i(mem_rdata)
  );

  // Synchronous MemoryUnit: registered read, write on strobe
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h14; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h30; d_wdata = 32'h0;
    tick(); tick();
    checks++;
    if ({if_ack, d_ack, mem_write} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {if_ack, d_ack, mem_write});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      failures++; $display("FAIL reset_words got=%h exp=0", {mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    rst_n = 1'b1;
    tick(); // first edge after release grants data
    checks++;
    if (mem_addr !== 32'h30) begin
      failures++; $display("FAIL reset_first_grant mem_addr got=%h exp=00000030", mem_addr);
    end
    tick(); tick();
    checks++;
    if (d_ack !== 1'b1 || if_ack !== 1'b0 || d_rdata !== 32'h12345678) begin
      failures++; $display("FAIL reset_first_ack d_ack=%b if_ack=%b d_rdata=%h exp 1 0 12345678", d_ack, if_ack, d_rdata);
    end
    d_req = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== 32'hA5A50001) begin
      failures++; $display("FAIL reset_loser_fetch if_ack=%b d_ack=%b if_rdata=%h exp 1 0 a5a50001", if_ack, d_ack, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    logic [3:0] ack_seq, wr_seen;
    if_req = 1'b1; if_addr = 32'h10;
    for (int c = 0; c < 4; c++) begin
      tick();
      ack_seq[c] = if_ack;
      wr_seen[c] = mem_write;
      if (c == 2) begin
        checks++;
        if (if_rdata !== 32'hDEADBEEF) begin
          failures++; $display("FAIL fetch_rdata got=%h exp=deadbeef", if_rdata);
        end
        if_req = 1'b0;
      end
    end
    checks++;
    if (ack_seq !== 4'b0100) begin
      failures++; $display("FAIL fetch_ack_timing got=%b exp=0100", ack_seq);
    end
    checks++;
    if (wr_seen !== 4'b0000) begin
      failures++; $display("FAIL fetch_mem_write got=%b exp=0000", wr_seen);
    end
  endtask

  task automatic test_write_read();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFEF00D;
    tick();
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hCAFEF00D) begin
      failures++; $display("FAIL write_issue we=%b addr=%h wdata=%h exp 1 20 cafef00d", mem_write, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if (mem_write !== 1'b0) begin
      failures++; $display("FAIL write_strobe_clear got=%b exp=0", mem_write);
    end
    tick();
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) begin
      failures++; $display("FAIL write_ack d_ack=%b d_rdata=%h exp 1 12345678", d_ack, d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick();
    checks++;
    if (d_ack !== 1'b0) begin
      failures++; $display("FAIL write_ack_pulse got=%b exp=0", d_ack);
    end
    d_req = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin
      failures++; $display("FAIL read_back d_ack=%b d_rdata=%h exp 1 cafef00d", d_ack, d_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    int t_d = -1, t_if = -1, both = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; if_req = 1'b1; if_addr = 32'h10;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (d_ack && if_ack) both++;
      if (d_ack && t_d < 0) begin t_d = c; d_req = 1'b0; end
      if (if_ack && t_if < 0) begin t_if = c; if_req = 1'b0; end
    end
    checks++;
    if (t_d !== 3 || t_if !== 6) begin
      failures++; $display("FAIL simul_order t_d=%0d t_if=%0d exp 3 6", t_d, t_if);
    end
    checks++;
    if (both !== 0) begin
      failures++; $display("FAIL simul_both_acks got=%0d exp=0", both);
    end
  endtask

  task automatic test_starvation();
    int n_if = 0, n_d = 0;
    logic [9:0] seq = '0;
    int n = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; if_req = 1'b1; if_addr = 32'h10;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int c = 0; c < 30; c++) begin
      tick();
      if ((if_ack || d_ack) && n < 10) begin seq[n] = if_ack; n++; end
    end
    checks++;
    if (n !== 10 || seq !== 10'b1000010000) begin
      failures++; $display("FAIL starve_pattern n=%0d seq=%b exp 10 1000010000", n, seq);
    end
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      if (if_ack) n_if++;
      if (d_ack)  n_d++;
    end
    checks++;
    if (n_if !== 0 || n_d !== 33) begin
      failures++; $display("FAIL starve_strict if_acks=%0d d_acks=%0d exp 0 33", n_if, n_d);
    end
`endif
    d_req = 1'b0; if_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_mid_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
    tick(); tick(); // now in CAPTURE
    rst_n = 1'b0;
    tick();
    checks++;
    if ({if_ack, d_ack, mem_write} !== 3'b000) begin
      failures++; $display("FAIL midrst_flags got=%b exp=000", {if_ack, d_ack, mem_write});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
      failures++; $display("FAIL midrst_words got=%h exp=0", {mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (d_ack !== 1'b0 || mem_addr !== 32'h30) begin
      failures++; $display("FAIL midrst_regrant d_ack=%b mem_addr=%h exp 0 30", d_ack, mem_addr);
    end
    tick(); tick();
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) begin
      failures++; $display("FAIL midrst_complete d_ack=%b d_rdata=%h exp 1 12345678", d_ack, d_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h14] = 32'hA5A50001;
    mem[8'h30] = 32'h12345678;
    test_reset();
    test_single_fetch();
    test_write_read();
    test_simultaneous();
    test_starvation();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
